// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC/valid-ready in, imem request/response, in-order (pc, instr) out to ID.
// Optional IF_MISALIGN_CHK_EN: misaligned PCs bypass memory and are offered as NOPs with if_misalign_o.
module if_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        if_misalign_o
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [FIFO_DEPTH-1:0][31:0] pc_mem;
    logic [FIFO_DEPTH-1:0]       mis_mem;
    logic [FIFO_DEPTH-1:0][31:0] d_mem;
    logic [AW-1:0]               pc_wr, pc_rd, d_wr, d_rd;
    logic [CW-1:0]               pc_cnt, d_cnt, pending_cnt, discard_cnt;

    logic [CW:0] credit_sum;
    logic        ok, mis_in, req_valid, req_fire, accept;
    logic        head_mis, pop, d_pop, rsp_keep, rsp_drop;

`ifdef IF_MISALIGN_CHK_EN
    assign mis_in = (pc_i[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    // Killed-but-unanswered requests still occupy credit until their words come back.
    assign credit_sum = {1'b0, pc_cnt} + {1'b0, discard_cnt};
    assign ok         = !flush_i && (credit_sum < DEPTH_L);
    assign req_valid  = pc_valid_i && ok && !mis_in;
    assign req_fire   = req_valid && imem_req_ready_i;
    assign accept     = pc_valid_i && ok && (mis_in || imem_req_ready_i);

    assign imem_req_valid_o = rst_ni && req_valid;
    assign imem_req_addr_o  = pc_i;
    assign pc_ready_o       = rst_ni && (flush_i || (ok && (mis_in || imem_req_ready_i)));

    assign head_mis   = (pc_cnt != '0) && mis_mem[pc_rd];
    assign if_valid_o = (pc_cnt != '0) && (head_mis || (d_cnt != '0));
    assign if_pc_o    = pc_mem[pc_rd];
    assign if_instr_o = head_mis ? NOP : d_mem[d_rd];
`ifdef IF_MISALIGN_CHK_EN
    assign if_misalign_o = head_mis;
`endif

    assign pop      = if_valid_o && if_ready_i && !flush_i;
    assign d_pop    = pop && !head_mis;
    assign rsp_keep = imem_rsp_valid_i && (discard_cnt == '0);
    assign rsp_drop = imem_rsp_valid_i && (discard_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_mem      <= '0;
            mis_mem     <= '0;
            d_mem       <= '0;
            pc_wr       <= '0;
            pc_rd       <= '0;
            d_wr        <= '0;
            d_rd        <= '0;
            pc_cnt      <= '0;
            d_cnt       <= '0;
            pending_cnt <= '0;
            discard_cnt <= '0;
        end else if (flush_i) begin
            pc_wr       <= '0;
            pc_rd       <= '0;
            d_wr        <= '0;
            d_rd        <= '0;
            pc_cnt      <= '0;
            d_cnt       <= '0;
            pending_cnt <= '0;
            // A response landing in the flush cycle answers one of the now-killed requests.
            discard_cnt <= discard_cnt + pending_cnt - CW'(rsp_keep);
        end else begin
            if (accept) begin
                pc_mem[pc_wr]  <= pc_i;
                mis_mem[pc_wr] <= mis_in;
                pc_wr          <= pc_wr + 1'b1;
            end
            if (pop) begin
                pc_rd <= pc_rd + 1'b1;
            end
            case ({accept, pop})
                2'b10:   pc_cnt <= pc_cnt + 1'b1;
                2'b01:   pc_cnt <= pc_cnt - 1'b1;
                default: ;
            endcase

            if (rsp_keep) begin
                d_mem[d_wr] <= imem_rsp_data_i;
                d_wr        <= d_wr + 1'b1;
            end
            if (d_pop) begin
                d_rd <= d_rd + 1'b1;
            end
            case ({rsp_keep, d_pop})
                2'b10:   d_cnt <= d_cnt + 1'b1;
                2'b01:   d_cnt <= d_cnt - 1'b1;
                default: ;
            endcase

            if (rsp_drop) begin
                discard_cnt <= discard_cnt - 1'b1;
            end
            pending_cnt <= pending_cnt + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    a_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> ((pending_cnt != '0) || (discard_cnt != '0)));
    a_pc_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> ({1'b0, pc_cnt} < DEPTH_L));
    a_data_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_keep && !flush_i) |-> (({1'b0, d_cnt} < DEPTH_L) || d_pop));
    a_data_le_pc: assert property (@(posedge clk_i) disable iff (!rst_ni)
        d_cnt <= pc_cnt);
    a_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, pending_cnt} + {1'b0, discard_cnt}) <= DEPTH_L);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: PC generator, variable-latency memory and ID consumer models.
// Define IF_MISALIGN_CHK_EN on both files to exercise the misaligned-PC path.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i, rst_ni;
    logic        pc_valid_i, pc_ready_o, flush_i;
    logic [31:0] pc_i;
    logic        imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
    logic [31:0] imem_req_addr_o, imem_rsp_data_i;
    logic        if_valid_o, if_ready_i;
    logic [31:0] if_pc_o, if_instr_o;
`ifdef IF_MISALIGN_CHK_EN
    logic        if_misalign_o;
`endif

    if_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pc_valid_i       (pc_valid_i),
        .pc_i             (pc_i),
        .pc_ready_o       (pc_ready_o),
        .flush_i          (flush_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .if_ready_i       (if_ready_i)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .if_misalign_o    (if_misalign_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    logic [31:0] pcs[$];
    int          hs_cyc[$];

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cyc = 0;
    int acc_count = 0;
    int hs_count = 0;
    int req_count = 0;
    int first_req_cyc = -1;
    int first_valid_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic drive_pc();
        pc_valid_i = (pcs.size() > 0);
        pc_i       = (pcs.size() > 0) ? pcs[0] : 32'h0;
    endtask

    // One clock: observe handshakes at the falling edge, then update stimulus just after the rising edge.
    task automatic cycle();
        logic  acc, fl, hs, mis;
        exp_t  e;
        acc = 1'b0;
        fl  = 1'b0;
        @(negedge clk_i);
        if (rst_ni) begin
            acc = pc_valid_i && pc_ready_o;
            fl  = flush_i;
            hs  = if_valid_o && if_ready_i && !flush_i;
            if (if_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hs) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("id_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("if_pc", if_pc_o, e.pc);
                    check("if_instr", if_instr_o, e.instr);
`ifdef IF_MISALIGN_CHK_EN
                    check("if_misalign", 32'(if_misalign_o), 32'(e.mis));
`endif
                end
            end
            if (fl) sb.delete();
            if (acc && !fl) begin
                acc_count++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
`ifdef IF_MISALIGN_CHK_EN
                mis = (pc_i[1:0] != 2'b00);
`else
                mis = 1'b0;
`endif
                sb.push_back('{pc: pc_i, instr: (mis ? NOP : mem_word(pc_i)), mis: mis});
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                req_count++;
                check("req_addr", imem_req_addr_o, pc_i);
                mq.push_back('{addr: imem_req_addr_o, due: cyc + lat});
            end
            check("inv_data_le_pc", 32'(dut.d_cnt <= dut.pc_cnt), 32'd1);
            check("inv_credit", 32'((int'(dut.pending_cnt) + int'(dut.discard_cnt)) <= DEPTH), 32'd1);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (rst_ni && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'h0;
        end
        // On a flush the generator keeps presenting the freshly loaded target.
        if (acc && !fl && pcs.size() > 0) void'(pcs.pop_front());
        drive_pc();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || pcs.size() != 0 || mq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
        cycle();
        cycle();
        #1;
        check({tag, "_idle_valid"}, 32'(if_valid_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni           = 1'b0;
        pc_valid_i       = 1'b1;
        pc_i             = 32'h80;
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        if_ready_i       = 1'b0;
        #12;
        check("rst_if_valid", 32'(if_valid_o), 32'd0);
        check("rst_if_pc", if_pc_o, 32'h0);
        check("rst_if_instr", if_instr_o, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("rst_pc_ready", 32'(pc_ready_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive_pc();

        // Sequential fetch with single-cycle memory.
        if_ready_i = 1'b1;
        pcs = '{32'h0, 32'h4, 32'h8};
        drive_pc();
        first_req_cyc = -1;
        first_valid_cyc = -1;
        hs_cyc.delete();
        drain("t1", 30);
        check("t1_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        check("t1_hs_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            check("t1_first_hs", 32'(hs_cyc[0] - first_req_cyc), 32'd2);
            check("t1_back_to_back", 32'(hs_cyc[2] - hs_cyc[0]), 32'd2);
        end

        // ID stalled: credit runs out after DEPTH requests, then everything drains in order.
        if_ready_i = 1'b0;
        acc_count = 0;
        hs_count = 0;
        pcs = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C};
        drive_pc();
        repeat (5) cycle();
        #1;
        check("t2_acc_count", 32'(acc_count), 32'(DEPTH));
        check("t2_pc_ready", 32'(pc_ready_o), 32'd0);
        check("t2_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("t2_if_valid", 32'(if_valid_o), 32'd1);
        if_ready_i = 1'b1;
        drain("t2", 60);
        check("t2_hs_count", 32'(hs_count), 32'd8);

        // Flush with two requests outstanding in a slow memory.
        lat = 3;
        pcs = '{32'h40, 32'h44};
        drive_pc();
        cycle();
        cycle();
        flush_i = 1'b1;
        pcs = '{32'h100, 32'h104, 32'h108};
        drive_pc();
        cycle();
        flush_i = 1'b0;
        #1;
        check("t3_discard", 32'(dut.discard_cnt), 32'd2);
        check("t3_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("t3_req_addr", imem_req_addr_o, 32'h100);
        check("t3_if_valid", 32'(if_valid_o), 32'd0);
        drain("t3", 60);
        check("t3_discard_done", 32'(dut.discard_cnt), 32'd0);
        lat = 1;

        // Flush coinciding with a response and an ID handshake.
        hs_count = 0;
        pcs = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C};
        drive_pc();
        n = 0;
        while (hs_count < 3 && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) check("t4_timeout", 32'd0, 32'd1);
        #1;
        check("t4_pre_if_valid", 32'(if_valid_o), 32'd1);
        check("t4_pre_pending", 32'(dut.pending_cnt), 32'd1);
        flush_i = 1'b1;
        pcs = '{32'h400, 32'h404};
        drive_pc();
        cycle();
        flush_i = 1'b0;
        #1;
        check("t4_if_valid", 32'(if_valid_o), 32'd0);
        check("t4_discard", 32'(dut.discard_cnt), 32'd0);
        drain("t4", 40);

        // Asynchronous reset with two requests outstanding and one word buffered.
        lat = 3;
        if_ready_i = 1'b0;
        pcs = '{32'h500, 32'h504, 32'h508};
        drive_pc();
        repeat (4) cycle();
        #1;
        check("t5_pre_if_valid", 32'(if_valid_o), 32'd1);
        check("t5_pre_pending", 32'(dut.pending_cnt), 32'd2);
        check("t5_pre_buffered", 32'(dut.d_cnt), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("t5_if_valid", 32'(if_valid_o), 32'd0);
        check("t5_if_pc", if_pc_o, 32'h0);
        check("t5_if_instr", if_instr_o, 32'h0);
        check("t5_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("t5_pc_ready", 32'(pc_ready_o), 32'd0);
        sb.delete();
        mq.delete();
        pcs.delete();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        drive_pc();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        lat = 1;
        if_ready_i = 1'b1;
        hs_count = 0;
        pcs = '{32'h600, 32'h604};
        drive_pc();
        drain("t5", 30);
        check("t5_hs_count", 32'(hs_count), 32'd2);

`ifdef IF_MISALIGN_CHK_EN
        // Misaligned PC bypasses memory and is offered as a NOP in order.
        req_count = 0;
        hs_count = 0;
        pcs = '{32'h0, 32'h6, 32'h8};
        drive_pc();
        drain("t6", 30);
        check("t6_req_count", 32'(req_count), 32'd2);
        check("t6_hs_count", 32'(hs_count), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
